// File: rtl/pc_pkg.sv
// pc_pkg: shared state encoding, RV32 default vectors and alignment helper for the PC generator
package pc_pkg;

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        HALTED
    } pc_state_e;

    localparam logic [31:0] RV32_RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] RV32_TRAP_VECTOR  = 32'h0000_0100;

    // Alignment only depends on the low address bits, so the bottom byte is enough for any unit up to 256 bytes
    function automatic logic is_aligned(input logic [7:0] addr_lo, input int unsigned instr_bytes);
        return (addr_lo & 8'(instr_bytes - 1)) == 8'h00;
    endfunction

endpackage

// File: rtl/pc_next_sel.sv
// pc_next_sel: combinational priority mux choosing the next PC and EPC
module pc_next_sel
    import pc_pkg::*;
#(
    parameter int               XLEN        = 32,
    parameter logic [XLEN-1:0]  TRAP_VECTOR = XLEN'(RV32_TRAP_VECTOR),
    parameter int               INSTR_BYTES = 4
) (
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] epc,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_pc,
    input  logic            mret_valid,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    input  logic            advance,
    output logic [XLEN-1:0] pc_next,
    output logic [XLEN-1:0] epc_next,
    output logic            misalign,
    output logic            flush
);

    logic aligned;

    // Trap beats mret beats redirect beats sequential advance; a misaligned redirect behaves like a trap on its target
    always_comb begin
        aligned  = is_aligned(redirect_target[7:0], INSTR_BYTES);
        misalign = redirect_valid && !aligned && !trap_valid && !mret_valid;
        flush    = trap_valid || mret_valid || redirect_valid;
        epc_next = trap_valid ? trap_pc : misalign ? redirect_target : epc;
        pc_next  = trap_valid     ? TRAP_VECTOR :
                   mret_valid     ? epc :
                   redirect_valid ? (aligned ? redirect_target : TRAP_VECTOR) :
                   advance        ? pc + XLEN'(INSTR_BYTES) : pc;
    end

endmodule

// File: rtl/pc_gen.sv
// pc_gen: fetch-stage program counter with handshake, redirect, trap/mret and halt control
module pc_gen
    import pc_pkg::*;
#(
    parameter int               XLEN         = 32,
    parameter logic [XLEN-1:0]  RESET_VECTOR = XLEN'(RV32_RESET_VECTOR),
    parameter logic [XLEN-1:0]  TRAP_VECTOR  = XLEN'(RV32_TRAP_VECTOR),
    parameter int               INSTR_BYTES  = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            fetch_ready,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_pc,
    input  logic            mret_valid,
    input  logic            halt_req,
    input  logic            resume_req,
    output logic            fetch_valid,
    output logic [XLEN-1:0] fetch_addr,
    output logic [XLEN-1:0] epc,
    output logic            halted,
    output logic            misalign_err
);

    pc_state_e       state, state_next;
    logic [XLEN-1:0] pc_next, epc_next;
    logic            misalign_next, flush, advance;

    assign advance = state == RUN && fetch_valid && fetch_ready;

    pc_next_sel #(
        .XLEN        (XLEN),
        .TRAP_VECTOR (TRAP_VECTOR),
        .INSTR_BYTES (INSTR_BYTES)
    ) u_next_sel (
        .pc              (fetch_addr),
        .epc             (epc),
        .trap_valid      (trap_valid),
        .trap_pc         (trap_pc),
        .mret_valid      (mret_valid),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .advance         (advance),
        .pc_next         (pc_next),
        .epc_next        (epc_next),
        .misalign        (misalign_next),
        .flush           (flush)
    );

    // Halt only when no control-flow event is pending; resume or a trap wakes a halted core
    always_comb begin
        state_next = state == BOOT ? RUN :
                     state == RUN  ? ((halt_req && !flush) ? HALTED : RUN) :
                     ((resume_req || trap_valid) ? RUN : HALTED);
    end

    // All outputs are registered from the next-state values so they change together
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= BOOT;
            fetch_addr   <= RESET_VECTOR;
            epc          <= '0;
            fetch_valid  <= 1'b0;
            halted       <= 1'b0;
            misalign_err <= 1'b0;
        end else begin
            state        <= state_next;
            fetch_addr   <= pc_next;
            epc          <= epc_next;
            fetch_valid  <= state_next == RUN;
            halted       <= state_next == HALTED;
            misalign_err <= misalign_next;
        end
    end

endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: directed and randomized checks of pc_gen (32-bit and 8-bit builds) against a behavioural model
module tb_pc_gen;

    localparam int S_BOOT = 0;
    localparam int S_RUN  = 1;
    localparam int S_HALT = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        fetch_ready = 1'b0, redirect_valid = 1'b0, trap_valid = 1'b0;
    logic        mret_valid = 1'b0, halt_req = 1'b0, resume_req = 1'b0;
    logic [31:0] redirect_target = '0, trap_pc = '0;

    logic        fv0, h0, me0, fv1, h1, me1;
    logic [31:0] fa0, epc0;
    logic [7:0]  fa1, epc1;

    int total = 0;
    int bad   = 0;

    logic [31:0] m_pc [2];
    logic [31:0] m_epc[2];
    logic [31:0] msk  [2];
    logic [31:0] rv   [2];
    logic [31:0] tv   [2];
    int          m_st [2];
    logic        m_mis[2];

    always #5 clk = ~clk;

    pc_gen #(.XLEN(32), .RESET_VECTOR(32'h80), .TRAP_VECTOR(32'h100), .INSTR_BYTES(4)) d0 (
        .clk(clk), .reset(reset), .fetch_ready(fetch_ready),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .trap_valid(trap_valid), .trap_pc(trap_pc), .mret_valid(mret_valid),
        .halt_req(halt_req), .resume_req(resume_req),
        .fetch_valid(fv0), .fetch_addr(fa0), .epc(epc0), .halted(h0), .misalign_err(me0)
    );

    pc_gen #(.XLEN(8), .RESET_VECTOR(8'h80), .TRAP_VECTOR(8'h40), .INSTR_BYTES(4)) d1 (
        .clk(clk), .reset(reset), .fetch_ready(fetch_ready),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target[7:0]),
        .trap_valid(trap_valid), .trap_pc(trap_pc[7:0]), .mret_valid(mret_valid),
        .halt_req(halt_req), .resume_req(resume_req),
        .fetch_valid(fv1), .fetch_addr(fa1), .epc(epc1), .halted(h1), .misalign_err(me1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_pc[i]  = rv[i];
            m_epc[i] = '0;
            m_st[i]  = S_BOOT;
            m_mis[i] = 1'b0;
        end
    endtask

    // One clock of architectural behaviour, applied to both widths
    task automatic model_step();
        logic [31:0] tp, rt;
        int          n;
        for (int i = 0; i < 2; i++) begin
            tp = trap_pc & msk[i];
            rt = redirect_target & msk[i];
            m_mis[i] = 1'b0;
            if (m_st[i] == S_BOOT) n = S_RUN;
            else if (m_st[i] == S_RUN) n = (halt_req && !(trap_valid || mret_valid || redirect_valid)) ? S_HALT : S_RUN;
            else n = (resume_req || trap_valid) ? S_RUN : S_HALT;
            if (trap_valid) begin
                m_epc[i] = tp;
                m_pc[i]  = tv[i];
            end else if (mret_valid) begin
                m_pc[i] = m_epc[i];
            end else if (redirect_valid) begin
                if (rt % 4 == 0) m_pc[i] = rt;
                else begin
                    m_mis[i] = 1'b1;
                    m_epc[i] = rt;
                    m_pc[i]  = tv[i];
                end
            end else if (m_st[i] == S_RUN && fetch_ready) begin
                m_pc[i] = (m_pc[i] + 32'd4) & msk[i];
            end
            m_st[i] = n;
        end
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        check("addr0",  fa0,         m_pc[0]);
        check("epc0",   epc0,        m_epc[0]);
        check("valid0", 32'(fv0),    32'(m_st[0] == S_RUN));
        check("halt0",  32'(h0),     32'(m_st[0] == S_HALT));
        check("mis0",   32'(me0),    32'(m_mis[0]));
        check("addr1",  32'(fa1),    m_pc[1]);
        check("epc1",   32'(epc1),   m_epc[1]);
        check("valid1", 32'(fv1),    32'(m_st[1] == S_RUN));
        check("halt1",  32'(h1),     32'(m_st[1] == S_HALT));
        check("mis1",   32'(me1),    32'(m_mis[1]));
    endtask

    task automatic clear_events();
        redirect_valid = 1'b0;
        trap_valid     = 1'b0;
        mret_valid     = 1'b0;
        halt_req       = 1'b0;
        resume_req     = 1'b0;
    endtask

    initial begin
        msk = '{32'hFFFF_FFFF, 32'h0000_00FF};
        rv  = '{32'h80, 32'h80};
        tv  = '{32'h100, 32'h40};
        reset = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_addr",  fa0,         32'h80);
        check("rst_valid", 32'(fv0),    32'h0);
        check("rst_halt",  32'(h0),     32'h0);
        check("rst_epc",   epc0,        32'h0);
        check("rst_mis",   32'(me0),    32'h0);

        // Boot: one cycle invalid, then sequential fetch from the reset vector
        fetch_ready = 1'b1;
        reset = 1'b0;
        cycle(); check("boot_addr", fa0, 32'h80); check("boot_valid", 32'(fv0), 32'h1);
        cycle(); check("seq_84", fa0, 32'h84);
        cycle(); check("seq_88", fa0, 32'h88);

        // Stall holds the address
        redirect_valid = 1'b1; redirect_target = 32'h10;
        cycle(); check("redir_10", fa0, 32'h10);
        clear_events(); fetch_ready = 1'b0;
        repeat (3) begin cycle(); check("stall_10", fa0, 32'h10); end
        fetch_ready = 1'b1;
        cycle(); check("stall_rel", fa0, 32'h14);

        // Trap beats redirect; mret returns to the saved PC
        fetch_ready = 1'b0;
        redirect_valid = 1'b1; redirect_target = 32'h40;
        trap_valid = 1'b1; trap_pc = 32'h20;
        cycle(); check("trap_addr", fa0, 32'h100); check("trap_epc", epc0, 32'h20);
        clear_events(); mret_valid = 1'b1;
        cycle(); check("mret_addr", fa0, 32'h20);
        clear_events();

        // Misaligned redirect
        redirect_valid = 1'b1; redirect_target = 32'h42;
        cycle(); check("mis_pulse", 32'(me0), 32'h1); check("mis_addr", fa0, 32'h100); check("mis_epc", epc0, 32'h42);
        clear_events();
        cycle(); check("mis_end", 32'(me0), 32'h0);

        // Halt after the accepted fetch advances, then resume
        fetch_ready = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h08;
        cycle(); check("redir_08", fa0, 32'h08);
        clear_events(); halt_req = 1'b1;
        cycle(); check("halt_addr", fa0, 32'h0C); check("halt_flag", 32'(h0), 32'h1); check("halt_valid", 32'(fv0), 32'h0);
        cycle(); check("halt_hold", fa0, 32'h0C);
        halt_req = 1'b1; resume_req = 1'b1;
        cycle(); check("resume_valid", 32'(fv0), 32'h1); check("resume_addr", fa0, 32'h0C);
        clear_events();
        cycle(); check("resume_adv", fa0, 32'h10);

        // 8-bit wrap
        redirect_valid = 1'b1; redirect_target = 32'hFC;
        cycle(); check("wrap_pre", 32'(fa1), 32'hFC);
        clear_events();
        cycle(); check("wrap_8", 32'(fa1), 32'h00); check("nowrap_32", fa0, 32'h100);

        // Random traffic
        for (int n = 0; n < 2000; n++) begin
            fetch_ready     = $urandom_range(0, 9) < 7;
            trap_valid      = $urandom_range(0, 29) == 0;
            trap_pc         = $urandom;
            mret_valid      = $urandom_range(0, 24) == 0;
            redirect_valid  = $urandom_range(0, 9) == 0;
            redirect_target = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
            halt_req        = $urandom_range(0, 14) == 0;
            resume_req      = $urandom_range(0, 5) == 0;
            cycle();
        end

        // Asynchronous reset in the middle of a stall
        clear_events(); fetch_ready = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h30;
        cycle();
        clear_events(); fetch_ready = 1'b0;
        cycle(); cycle();
        #2;
        reset = 1'b1;
        #1;
        check("arst_addr0",  fa0,       32'h80);
        check("arst_valid0", 32'(fv0),  32'h0);
        check("arst_addr1",  32'(fa1),  32'h80);
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0; fetch_ready = 1'b1;
        repeat (4) cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
